// File: rtl/alu_issue_unit_if.sv
// Bundled instruction, register-load, ALU and completion signals of alu_issue_unit.
// Instruction handshake: a transfer happens on a rising clock edge where instr_valid_in
// and instr_ready_out are both high; the offered fields must stay stable while valid is high.
interface alu_issue_unit_if;
  logic              instr_valid_in;
  logic              instr_ready_out;
  logic [2:0]        instr_opcode_in;
  logic [2:0]        instr_src1_in;
  logic [2:0]        instr_src2_in;
  logic [2:0]        instr_dest_in;
  logic              reg_write_valid_in;
  logic [2:0]        reg_write_addr_in;
  logic signed [7:0] reg_write_data_in;
  logic              alu_enable_out;
  logic [2:0]        alu_opcode_out;
  logic signed [7:0] alu_input1_out;
  logic signed [7:0] alu_input2_out;
  logic signed [7:0] alu_result_in;
  logic              done_out;
  logic [2:0]        done_dest_out;
  logic signed [7:0] done_data_out;
  logic              busy_out;
  logic              illegal_out;
  logic [1:0]        state_dbg_out;

  modport slave (
    input  instr_valid_in, instr_opcode_in, instr_src1_in, instr_src2_in, instr_dest_in,
    input  reg_write_valid_in, reg_write_addr_in, reg_write_data_in, alu_result_in,
    output instr_ready_out, alu_enable_out, alu_opcode_out, alu_input1_out, alu_input2_out,
    output done_out, done_dest_out, done_data_out, busy_out, illegal_out, state_dbg_out
  );

  modport master (
    output instr_valid_in, instr_opcode_in, instr_src1_in, instr_src2_in, instr_dest_in,
    output reg_write_valid_in, reg_write_addr_in, reg_write_data_in, alu_result_in,
    input  instr_ready_out, alu_enable_out, alu_opcode_out, alu_input1_out, alu_input2_out,
    input  done_out, done_dest_out, done_data_out, busy_out, illegal_out, state_dbg_out
  );
endinterface

// File: rtl/alu_issue_unit.sv
// Buffers ALU instructions in a 4-deep FIFO and issues them one at a time against an
// 8x8 signed register file, writing each result back before the next instruction issues.
module alu_issue_unit (
  input logic             clock_in,
  input logic             reset_in,
  alu_issue_unit_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WRITEBACK = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [11:0]       fifo_q [4];
  logic [11:0]       fifo_d [4];
  logic [1:0]        wr_ptr_q, wr_ptr_d;
  logic [1:0]        rd_ptr_q, rd_ptr_d;
  logic [2:0]        count_q, count_d;
  logic [11:0]       instr_q, instr_d;
  logic signed [7:0] rf_q [8];
  logic signed [7:0] rf_d [8];
  logic              illegal_q, illegal_d;
  logic [2:0]        alu_op_hold_q, alu_op_hold_d;
  logic signed [7:0] alu_in1_hold_q, alu_in1_hold_d;
  logic signed [7:0] alu_in2_hold_q, alu_in2_hold_d;
  logic [2:0]        done_dest_hold_q, done_dest_hold_d;
  logic signed [7:0] done_data_hold_q, done_data_hold_d;

  // Instruction word layout: {opcode[11:9], src1[8:6], src2[5:3], dest[2:0]}
  logic              push, pop, head_legal;
  logic [11:0]       head;
  logic signed [7:0] rd_a, rd_b;

  assign push       = bus.instr_valid_in && (count_q != 3'd4);
  assign pop        = (state_q == S_IDLE) && (count_q != 3'd0);
  assign head       = fifo_q[rd_ptr_q];
  assign head_legal = (head[11:9] <= 3'd4);
  assign rd_a       = rf_q[instr_q[8:6]];
  assign rd_b       = rf_q[instr_q[5:3]];

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (pop && head_legal) state_d = S_ISSUE;
      S_ISSUE:     state_d = S_WRITEBACK;
      S_WRITEBACK: state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fifo_d           = fifo_q;
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    instr_d          = instr_q;
    rf_d             = rf_q;
    illegal_d        = illegal_q | (pop && !head_legal);
    alu_op_hold_d    = alu_op_hold_q;
    alu_in1_hold_d   = alu_in1_hold_q;
    alu_in2_hold_d   = alu_in2_hold_q;
    done_dest_hold_d = done_dest_hold_q;
    done_data_hold_d = done_data_hold_q;
    count_d          = count_q + {2'b00, push} - {2'b00, pop};
    if (push) begin
      fifo_d[wr_ptr_q] = {bus.instr_opcode_in, bus.instr_src1_in, bus.instr_src2_in, bus.instr_dest_in};
      wr_ptr_d         = wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
      if (head_legal) instr_d = head;
    end
    if (state_q == S_ISSUE) begin
      alu_op_hold_d  = instr_q[11:9];
      alu_in1_hold_d = rd_a;
      alu_in2_hold_d = rd_b;
    end
    // External load first so that a same-address writeback overrides it.
    if (bus.reg_write_valid_in) rf_d[bus.reg_write_addr_in] = bus.reg_write_data_in;
    if (state_q == S_WRITEBACK) begin
      rf_d[instr_q[2:0]] = bus.alu_result_in;
      done_dest_hold_d   = instr_q[2:0];
      done_data_hold_d   = bus.alu_result_in;
    end
  end

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      instr_q          <= '0;
      illegal_q        <= 1'b0;
      alu_op_hold_q    <= '0;
      alu_in1_hold_q   <= '0;
      alu_in2_hold_q   <= '0;
      done_dest_hold_q <= '0;
      done_data_hold_q <= '0;
    end else begin
      fifo_q           <= fifo_d;
      rf_q             <= rf_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      instr_q          <= instr_d;
      illegal_q        <= illegal_d;
      alu_op_hold_q    <= alu_op_hold_d;
      alu_in1_hold_q   <= alu_in1_hold_d;
      alu_in2_hold_q   <= alu_in2_hold_d;
      done_dest_hold_q <= done_dest_hold_d;
      done_data_hold_q <= done_data_hold_d;
    end
  end

  // ALU and completion outputs show live values only in their state, otherwise the last ones.
  always_comb begin
    bus.instr_ready_out = (count_q != 3'd4);
    bus.alu_enable_out  = (state_q == S_ISSUE);
    bus.alu_opcode_out  = (state_q == S_ISSUE) ? instr_q[11:9] : alu_op_hold_q;
    bus.alu_input1_out  = (state_q == S_ISSUE) ? rd_a : alu_in1_hold_q;
    bus.alu_input2_out  = (state_q == S_ISSUE) ? rd_b : alu_in2_hold_q;
    bus.done_out        = (state_q == S_WRITEBACK);
    bus.done_dest_out   = (state_q == S_WRITEBACK) ? instr_q[2:0] : done_dest_hold_q;
    bus.done_data_out   = (state_q == S_WRITEBACK) ? bus.alu_result_in : done_data_hold_q;
    bus.busy_out        = (state_q != S_IDLE) || (count_q != 3'd0);
    bus.illegal_out     = illegal_q;
    bus.state_dbg_out   = state_q;
  end
endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: an instruction-level model predicts every output each cycle,
// a responder plays the downstream ALU, and directed sequences pin literal values.
module tb_alu_issue_unit;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_issue_unit_if u_if ();

  alu_issue_unit dut (
    .clock_in (clk),
    .reset_in (rst_n),
    .bus      (u_if.slave)
  );

  int tests = 0;
  int fails = 0;
  int cycle = 0;
  int en_count = 0;
  int done_cyc_log[$];
  logic [2:0] done_dest_log[$];

  // Model: pending instructions, register file, and what the ALU side last showed.
  logic [11:0]       exp_q[$];
  logic [11:0]       m_cur;
  int                m_stage;
  logic signed [7:0] m_rf [8];
  bit                m_illegal;
  logic [2:0]        m_last_op, m_last_dest;
  logic signed [7:0] m_last_a, m_last_b, m_last_data, m_exp_result;
  bit                force_en = 1'b0;
  logic signed [7:0] force_val = '0;

  function automatic logic signed [7:0] alu_fn(input logic [2:0] op,
                                               input logic signed [7:0] a,
                                               input logic signed [7:0] b);
    logic signed [15:0] p;
    p = a * b;
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return p[7:0];
      3'd3:    return {7'b0, a == b};
      3'd4:    return {7'b0, a > b};
      default: return '0;
    endcase
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cycle, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_stage = 0; m_cur = '0; m_illegal = 1'b0;
    for (int i = 0; i < 8; i++) m_rf[i] = '0;
    m_last_op = '0; m_last_dest = '0; m_last_a = '0; m_last_b = '0;
    m_last_data = '0; m_exp_result = '0;
  endtask

  task automatic model_step();
    logic [11:0] head;
    bit do_push, do_wb;
    do_push = u_if.instr_valid_in && (exp_q.size() < 4);
    do_wb = 1'b0;
    if (m_stage == 0) begin
      if (exp_q.size() != 0) begin
        head = exp_q.pop_front();
        if (head[11:9] > 3'd4) m_illegal = 1'b1;
        else begin m_cur = head; m_stage = 1; end
      end
    end else if (m_stage == 1) begin
      m_last_op = m_cur[11:9];
      m_last_a = m_rf[m_cur[8:6]];
      m_last_b = m_rf[m_cur[5:3]];
      m_exp_result = force_en ? force_val : alu_fn(m_last_op, m_last_a, m_last_b);
      m_stage = 2;
    end else begin
      do_wb = 1'b1;
      m_last_dest = m_cur[2:0];
      m_last_data = m_exp_result;
      m_stage = 0;
    end
    if (u_if.reg_write_valid_in) m_rf[u_if.reg_write_addr_in] = u_if.reg_write_data_in;
    if (do_wb) m_rf[m_cur[2:0]] = m_exp_result;
    if (do_push)
      exp_q.push_back({u_if.instr_opcode_in, u_if.instr_src1_in, u_if.instr_src2_in, u_if.instr_dest_in});
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Downstream ALU: result appears only in the cycle after the enable cycle.
  initial begin
    logic signed [7:0] pend;
    bit pend_v;
    pend_v = 1'b0;
    pend = '0;
    u_if.alu_result_in = '0;
    forever begin
      @(posedge clk); #2;
      if (u_if.alu_enable_out) begin
        pend = force_en ? force_val
                        : alu_fn(u_if.alu_opcode_out, u_if.alu_input1_out, u_if.alu_input2_out);
        pend_v = 1'b1;
        u_if.alu_result_in = 8'($urandom);
      end else if (pend_v) begin
        u_if.alu_result_in = pend;
        pend_v = 1'b0;
      end else begin
        u_if.alu_result_in = 8'($urandom);
      end
    end
  end

  initial begin
    logic issuing, writing;
    forever begin
      @(negedge clk);
      cycle++;
      issuing = (m_stage == 1);
      writing = (m_stage == 2);
      check("ready", u_if.instr_ready_out, exp_q.size() < 4);
      check("busy", u_if.busy_out, (m_stage != 0) || (exp_q.size() != 0));
      check("illegal", u_if.illegal_out, m_illegal);
      check("alu_en", u_if.alu_enable_out, issuing);
      check("alu_op", u_if.alu_opcode_out, issuing ? m_cur[11:9] : m_last_op);
      check("alu_in1", u_if.alu_input1_out, issuing ? m_rf[m_cur[8:6]] : m_last_a);
      check("alu_in2", u_if.alu_input2_out, issuing ? m_rf[m_cur[5:3]] : m_last_b);
      check("done", u_if.done_out, writing);
      check("done_dest", u_if.done_dest_out, writing ? m_cur[2:0] : m_last_dest);
      check("done_data", u_if.done_data_out, writing ? m_exp_result : m_last_data);
      if (u_if.done_out) begin
        done_cyc_log.push_back(cycle);
        done_dest_log.push_back(u_if.done_dest_out);
      end
      if (u_if.alu_enable_out) en_count++;
    end
  end

  task automatic load_reg(input logic [2:0] a, input logic signed [7:0] d);
    @(posedge clk); #1;
    u_if.reg_write_valid_in = 1'b1;
    u_if.reg_write_addr_in = a;
    u_if.reg_write_data_in = d;
    @(posedge clk); #1;
    u_if.reg_write_valid_in = 1'b0;
  endtask

  task automatic drive_instr(input logic [2:0] op, input logic [2:0] s1,
                             input logic [2:0] s2, input logic [2:0] d);
    u_if.instr_opcode_in = op;
    u_if.instr_src1_in = s1;
    u_if.instr_src2_in = s2;
    u_if.instr_dest_in = d;
  endtask

  // Offers one instruction for one edge; returns 1 time unit after that edge.
  task automatic push_one(input logic [2:0] op, input logic [2:0] s1,
                          input logic [2:0] s2, input logic [2:0] d);
    @(posedge clk); #1;
    drive_instr(op, s1, s2, d);
    u_if.instr_valid_in = 1'b1;
    @(posedge clk); #1;
    u_if.instr_valid_in = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (((exp_q.size() != 0) || (m_stage != 0)) && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    tests++;
    if (guard >= 200) begin
      fails++;
      $display("FAIL wait_idle: model still busy after %0d cycles, required idle", guard);
    end
    @(posedge clk); #1;
  endtask

  // After push_one: checks the idle cycle, the issue cycle and the completion cycle.
  task automatic expect_issue(input string tag, input logic [2:0] op, input logic [7:0] a,
                              input logic [7:0] b, input logic [2:0] d, input logic [7:0] r);
    @(negedge clk);
    check({tag, "_e0_en"}, u_if.alu_enable_out, 1'b0);
    @(negedge clk);
    check({tag, "_en"}, u_if.alu_enable_out, 1'b1);
    check({tag, "_op"}, u_if.alu_opcode_out, op);
    check({tag, "_in1"}, u_if.alu_input1_out, a);
    check({tag, "_in2"}, u_if.alu_input2_out, b);
    @(negedge clk);
    check({tag, "_done"}, u_if.done_out, 1'b1);
    check({tag, "_dest"}, u_if.done_dest_out, d);
    check({tag, "_data"}, u_if.done_data_out, r);
  endtask

  initial begin
    int k, guard, base, en_base;
    bit accepted;
    u_if.instr_valid_in = 1'b0;
    u_if.reg_write_valid_in = 1'b0;
    u_if.reg_write_addr_in = '0;
    u_if.reg_write_data_in = '0;
    drive_instr(3'd0, 3'd0, 3'd0, 3'd0);
    #1;
    check("rst_ready", u_if.instr_ready_out, 1'b1);
    check("rst_busy", u_if.busy_out, 1'b0);
    check("rst_en", u_if.alu_enable_out, 1'b0);
    check("rst_done", u_if.done_out, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic add, then a dependent subtract reading the written-back value.
    load_reg(3'd1, 8'sd5);
    load_reg(3'd2, 8'sd3);
    push_one(3'd0, 3'd1, 3'd2, 3'd3);
    expect_issue("add", 3'd0, 8'd5, 8'd3, 3'd3, 8'd8);
    wait_idle();
    push_one(3'd1, 3'd3, 3'd1, 3'd4);
    expect_issue("chain", 3'd1, 8'd8, 8'd5, 3'd4, 8'd3);
    wait_idle();

    // Six back-to-back offers; the sixth fills the FIFO.
    base = done_dest_log.size();
    k = 0;
    guard = 0;
    @(posedge clk); #1;
    drive_instr(3'($urandom_range(0, 4)), 3'($urandom), 3'($urandom), 3'(k));
    u_if.instr_valid_in = 1'b1;
    while (k < 6 && guard < 100) begin
      @(negedge clk);
      accepted = u_if.instr_ready_out;
      if (accepted) k++;
      @(posedge clk); #1;
      if (k < 6) drive_instr(3'($urandom_range(0, 4)), 3'($urandom), 3'($urandom), 3'(k));
      else u_if.instr_valid_in = 1'b0;
      guard++;
    end
    check("burst_accepted", 8'(k), 8'd6);
    @(negedge clk);
    check("burst_full_ready", u_if.instr_ready_out, 1'b0);
    wait_idle();
    check("burst_done_count", 8'(done_dest_log.size() - base), 8'd6);
    for (int i = 0; i < 6; i++) begin
      if (base + i < done_dest_log.size()) check("burst_order", done_dest_log[base + i], 8'(i));
      if (i > 0 && base + i < done_cyc_log.size())
        check("burst_spacing", 8'(done_cyc_log[base + i] - done_cyc_log[base + i - 1]), 8'd3);
    end

    // Illegal opcode is dropped, the following ADD completes.
    base = done_dest_log.size();
    en_base = en_count;
    push_one(3'd6, 3'd1, 3'd2, 3'd5);
    push_one(3'd0, 3'd1, 3'd2, 3'd7);
    wait_idle();
    check("illegal_sticky", u_if.illegal_out, 1'b1);
    check("illegal_enables", 8'(en_count - en_base), 8'd1);
    check("illegal_dones", 8'(done_dest_log.size() - base), 8'd1);
    if (done_dest_log.size() > base) check("illegal_next_dest", done_dest_log[base], 3'd7);

    // External write and writeback hit r3 on the same edge.
    force_en = 1'b1;
    force_val = 8'sh22;
    push_one(3'd0, 3'd1, 3'd2, 3'd3);
    @(posedge clk);
    @(posedge clk); #1;
    u_if.reg_write_valid_in = 1'b1;
    u_if.reg_write_addr_in = 3'd3;
    u_if.reg_write_data_in = 8'sh11;
    @(posedge clk); #1;
    u_if.reg_write_valid_in = 1'b0;
    wait_idle();
    force_en = 1'b0;
    push_one(3'd0, 3'd3, 3'd3, 3'd6);
    @(negedge clk);
    @(negedge clk);
    check("collide_r3", u_if.alu_input1_out, 8'h22);
    wait_idle();

    // Reset during ISSUE, then a wrapping subtract.
    push_one(3'd0, 3'd1, 3'd2, 3'd6);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("arst_en", u_if.alu_enable_out, 1'b0);
    check("arst_ready", u_if.instr_ready_out, 1'b1);
    check("arst_busy", u_if.busy_out, 1'b0);
    check("arst_done", u_if.done_out, 1'b0);
    check("arst_illegal", u_if.illegal_out, 1'b0);
    check("arst_in1", u_if.alu_input1_out, 8'd0);
    check("arst_ddata", u_if.done_data_out, 8'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    base = done_dest_log.size();
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_dones", 8'(done_dest_log.size() - base), 8'd0);
    check("post_rst_busy", u_if.busy_out, 1'b0);
    load_reg(3'd1, -8'sd128);
    load_reg(3'd2, 8'sd1);
    push_one(3'd1, 3'd1, 3'd2, 3'd5);
    expect_issue("wrap", 3'd1, 8'h80, 8'h01, 3'd5, 8'h7F);
    wait_idle();
    push_one(3'd0, 3'd5, 3'd0, 3'd6);
    @(negedge clk);
    @(negedge clk);
    check("wrap_r5", u_if.alu_input1_out, 8'h7F);
    wait_idle();

    // Random traffic with concurrent register loads.
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      u_if.instr_valid_in = 1'($urandom_range(0, 1));
      drive_instr((($urandom_range(0, 9)) == 9) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4)),
                  3'($urandom), 3'($urandom), 3'($urandom));
      u_if.reg_write_valid_in = ($urandom_range(0, 3) == 0);
      u_if.reg_write_addr_in = 3'($urandom);
      u_if.reg_write_data_in = 8'($urandom);
    end
    @(posedge clk); #1;
    u_if.instr_valid_in = 1'b0;
    u_if.reg_write_valid_in = 1'b0;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
